acc_array: RTL and testbench
============================

# acc_array

Multi-channel, parametrised successor to the single-lane int16 accumulator. Holds NCH independent signed saturating accumulators of ACC_W bits, each fed by its own valid/data lane with preload and clear. A drain sequencer streams every channel out in order over a valid/ready handshake, as the full-width value and as a rounded, right-shifted, saturated OUT_W value. It sits between the PE array partial-sum outputs and the writeback/requant path.

## Interface
- NCH, 4: number of accumulator channels (≥2).
- IN_W, 16: signed input data width per channel (IN_W ≤ ACC_W).
- ACC_W, 16: signed accumulator width.
- OUT_W, 8: signed narrow output width (OUT_W < ACC_W).
- SHW, $clog2(ACC_W): width of the shift control.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- acc_clr  in  1  global synchronous clear of all channels and sequencer.
- acc_vld  in  NCH  per-channel accumulate strobe.
- acc_data  in  NCH*IN_W  packed signed addends, channel c at [c*IN_W +: IN_W].
- load_vld  in  NCH  per-channel preload strobe.
- load_data  in  NCH*ACC_W  packed preload values.
- drain_start  in  1  pulse that starts a drain.
- drain_clr  in  1  sampled with drain_start; clears each channel after its beat.
- out_shift  in  SHW  arithmetic right shift for the narrow output, sampled with drain_start.
- out_vld  out  1  drain beat valid.
- out_rdy  in  1  downstream ready.
- out_ch  out  $clog2(NCH)  channel index of the current beat.
- out_last  out  1  current beat is channel NCH-1.
- out_wide  out  ACC_W  raw accumulator value of out_ch.
- out_narrow  out  OUT_W  rounded/shifted/saturated value of out_ch.
- busy  out  1  drain in progress.
- sat_flag  out  NCH  sticky per-channel saturation indicator.
- drop_err  out  1  sticky: acc_vld/load_vld seen while busy.

## Operation
- Reset: all accumulators 0, sat_flag 0, drop_err 0, state IDLE, out_vld 0, busy 0, out_ch 0, out_last 0.
- Per-channel priority each cycle: acc_clr > load_vld[c] > acc_vld[c] > hold.
- Accumulate: the addend is sign-extended to ACC_W. The sum is computed at ACC_W+1 bits.
  - Positive overflow gives 2^(ACC_W-1)-1.
  - Negative overflow gives -2^(ACC_W-1).
  - Either case sets sat_flag[c].
- Load writes load_data verbatim, with no flag change.
- acc_clr zeroes every accumulator, sat_flag and drop_err, and forces IDLE.
- States:
  - IDLE: drain_start (with acc_clr low) moves to DRAIN. It latches drain_clr and out_shift, and sets out_ch to 0.
  - DRAIN: out_vld=1. A beat completes when out_vld & out_rdy.
    - On a completed beat with out_ch<NCH-1: increment out_ch. If drain_clr was latched, zero channel out_ch and its sat_flag.
    - On a completed beat with out_ch=NCH-1: return to IDLE and apply the same optional clear.
- While busy, acc_vld/load_vld are ignored (no state change) and set drop_err. drain_start while busy is ignored.
- Narrow cast, with s = latched shift:
  - If s=0: v = acc.
  - Otherwise: v = (acc + 2^(s-1)) >>> s, computed at ACC_W+1 bits (round half up).
  - Saturate v to the OUT_W signed range: above 2^(OUT_W-1)-1 gives 0x7F..; below -2^(OUT_W-1) gives 0x80...
- out_wide and out_narrow are combinational from the selected accumulator. They are stable for a beat because accumulation is frozen while busy.

## Timing
- Accumulate/load/clear: result visible on out_wide one cycle after the strobe.
- drain_start at cycle N gives busy=out_vld=1 and out_ch=0 at N+1.
- With out_rdy held high, beat k is at N+1+k. The last beat is at N+NCH. busy=0 at N+NCH+1.
- out_rdy low: out_vld, out_ch, out_wide and out_narrow hold unchanged.
- acc_clr during DRAIN: out_vld and busy drop the next cycle. The beat in that cycle is not considered completed. All channels are zero.
- Async reset mid-drain: outputs go to reset values immediately. There is no partial clear.
- drain_start and acc_vld in the same IDLE cycle: the accumulate is applied and the drain starts. Beat 0 shows the updated value.

## Test plan
NCH=4, ACC_W=16, OUT_W=8.
- Overflow: load ch0=0x7FF0, then acc 0x0020 → out_wide 0x7FFF, sat_flag[0]=1. Then acc 0xFFFF → 0x7FFE, and the flag stays set.
- Underflow: load ch1=0x8005, then acc 0xFFF0 → 0x8000, sat_flag[1]=1. Simultaneous load_vld+acc_vld on ch2 → the load value wins.
- Cast:
  - ch0=0x0123, s=0 → out_narrow 0x7F.
  - ch0=0x0123, s=2 → 0x49.
  - ch1=0xFF80 → 0x80.
  - ch1=0xFF7F → 0x80.
  - ch2=0x0006, s=2 → 0x02.
  - ch3=0xFFFA, s=2 → 0xFF.
- Drain with backpressure: toggle out_rdy 1,0,0,1,… → out_ch goes 0..3 once each. Values hold while stalled. out_last only on ch3. busy falls the cycle after the ch3 handshake.
- drain_clr=1: after the drain, all channels read 0 and sat_flag=0. acc_vld pulsed mid-drain → ignored, drop_err=1.
- acc_clr asserted at beat 1 of a drain → out_vld=0 the next cycle, all channels 0, state IDLE. A new drain_start works normally.

Source files
------------

// File: rtl/acc_array.sv
// acc_array: NCH signed saturating accumulators with preload/clear and a
// handshaked drain sequencer emitting wide and rounded/saturated narrow values.
module acc_array #(
  parameter int NCH = 4,
  parameter int IN_W = 16,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int SHW = $clog2(ACC_W),
  localparam int CW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_clr,
  input  logic [NCH-1:0]       acc_vld,
  input  logic [NCH*IN_W-1:0]  acc_data,
  input  logic [NCH-1:0]       load_vld,
  input  logic [NCH*ACC_W-1:0] load_data,
  input  logic                 drain_start,
  input  logic                 drain_clr,
  input  logic [SHW-1:0]       out_shift,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [CW-1:0]        out_ch,
  output logic                 out_last,
  output logic [ACC_W-1:0]     out_wide,
  output logic [OUT_W-1:0]     out_narrow,
  output logic                 busy,
  output logic [NCH-1:0]       sat_flag,
  output logic                 drop_err
);
  typedef enum logic {IDLE, DRAIN} state_t;
  localparam logic signed [ACC_W:0] V_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] V_MIN = ~V_MAX;
  state_t state, state_nx;
  logic [CW-1:0] ch_nx;
  logic clr_lat, beat, start;
  logic [SHW-1:0] shift;
  logic [ACC_W-1:0] acc [NCH];
  logic [ACC_W-1:0] acc_sum [NCH];
  logic [NCH-1:0] ovf;
  logic [ACC_W-1:0] sel;
  logic signed [ACC_W:0] half, v;
  assign busy = state == DRAIN;
  assign out_vld = busy;
  assign beat = busy & out_rdy;
  assign start = (state == IDLE) & drain_start & ~acc_clr;
  assign out_last = busy & (out_ch == CW'(NCH-1));
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic signed [ACC_W:0] sum;
    assign sum = $signed({acc[g][ACC_W-1], acc[g]}) + (ACC_W+1)'($signed(acc_data[g*IN_W +: IN_W]));
    // sign bit and bit below disagree exactly when the ACC_W result overflowed
    assign ovf[g] = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_sum[g] = !ovf[g] ? sum[ACC_W-1:0] :
                        sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
  always_comb begin
    state_nx = state;
    ch_nx = out_ch;
    if (acc_clr) begin
      state_nx = IDLE;
      ch_nx = '0;
    end else if (start) begin
      state_nx = DRAIN;
      ch_nx = '0;
    end else if (beat) begin
      state_nx = out_last ? IDLE : DRAIN;
      ch_nx = out_last ? '0 : out_ch + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_ch <= '0;
      clr_lat <= 1'b0;
      shift <= '0;
    end else begin
      state <= state_nx;
      out_ch <= ch_nx;
      if (start) begin
        clr_lat <= drain_clr;
        shift <= out_shift;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
      sat_flag <= '0;
      drop_err <= 1'b0;
    end else if (acc_clr) begin
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
      sat_flag <= '0;
      drop_err <= 1'b0;
    end else begin
      if (busy && (|acc_vld || |load_vld)) drop_err <= 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (busy) begin
          if (beat && clr_lat && out_ch == CW'(c)) begin
            acc[c] <= '0;
            sat_flag[c] <= 1'b0;
          end
        end else if (load_vld[c]) begin
          acc[c] <= load_data[c*ACC_W +: ACC_W];
        end else if (acc_vld[c]) begin
          acc[c] <= acc_sum[c];
          sat_flag[c] <= sat_flag[c] | ovf[c];
        end
      end
    end
  end
  assign sel = acc[out_ch];
  assign out_wide = sel;
  // rounding bias is added at ACC_W+1 bits so the largest value cannot wrap
  assign half = (shift == '0) ? '0 : (ACC_W+1)'(1) << (shift - SHW'(1));
  assign v = ($signed({sel[ACC_W-1], sel}) + half) >>> shift;
  assign out_narrow = (v > V_MAX) ? {1'b0, {(OUT_W-1){1'b1}}} :
                      (v < V_MIN) ? {1'b1, {(OUT_W-1){1'b0}}} : v[OUT_W-1:0];
endmodule

// File: tb/tb_acc_array.sv
// tb_acc_array: randomized and directed checks of acc_array against an
// arithmetic reference model of the channels, flags and drain sequence.
module tb_acc_array;
  localparam int NCH = 4, IN_W = 16, ACC_W = 16, OUT_W = 8, SHW = 4;
  logic clk = 0, rst_n = 0, acc_clr = 0;
  logic [NCH-1:0] acc_vld = 0, load_vld = 0;
  logic [NCH*IN_W-1:0] acc_data = 0;
  logic [NCH*ACC_W-1:0] load_data = 0;
  logic drain_start = 0, drain_clr = 0, out_rdy = 0;
  logic [SHW-1:0] out_shift = 0;
  logic out_vld, out_last, busy, drop_err;
  logic [1:0] out_ch;
  logic [ACC_W-1:0] out_wide;
  logic [OUT_W-1:0] out_narrow;
  logic [NCH-1:0] sat_flag;
  int pass_n = 0, total_n = 0;
  int m [NCH];
  logic [NCH-1:0] m_sat = 0;
  logic m_drop = 0;

  acc_array #(.NCH(NCH), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .acc_vld(acc_vld), .acc_data(acc_data),
    .load_vld(load_vld), .load_data(load_data), .drain_start(drain_start),
    .drain_clr(drain_clr), .out_shift(out_shift), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_ch(out_ch), .out_last(out_last), .out_wide(out_wide), .out_narrow(out_narrow),
    .busy(busy), .sat_flag(sat_flag), .drop_err(drop_err));

  always #5 clk = ~clk;

  function automatic int s16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic int clamp(input int x, input int lo, input int hi);
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction

  function automatic int narrow(input int a, input int s);
    int v;
    v = (s == 0) ? a : ((a + (1 << (s - 1))) >>> s);
    return clamp(v, -128, 127);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_upd(input logic [3:0] lv, input logic [63:0] ld,
                           input logic [3:0] av, input logic [63:0] ad);
    int s;
    for (int c = 0; c < NCH; c++) begin
      if (lv[c]) m[c] = s16(ld[c*16 +: 16]);
      else if (av[c]) begin
        s = m[c] + s16(ad[c*16 +: 16]);
        if (clamp(s, -32768, 32767) != s) m_sat[c] = 1'b1;
        m[c] = clamp(s, -32768, 32767);
      end
    end
  endtask

  task automatic step(input logic [3:0] lv, input logic [63:0] ld,
                      input logic [3:0] av, input logic [63:0] ad);
    load_vld = lv; load_data = ld; acc_vld = av; acc_data = ad;
    tick;
    load_vld = 0; acc_vld = 0;
    model_upd(lv, ld, av, ad);
  endtask

  task automatic model_clear;
    for (int c = 0; c < NCH; c++) m[c] = 0;
    m_sat = 0;
    m_drop = 0;
  endtask

  // mode 0: ready held high, 1: pattern 1,0,0 repeating, 2: random
  task automatic drain(input int s, input bit clr, input int mode, input bit poke,
                       input logic [3:0] av, input logic [63:0] ad);
    int e, cyc;
    drain_start = 1; drain_clr = clr; out_shift = SHW'(s); acc_vld = av; acc_data = ad;
    tick;
    drain_start = 0; drain_clr = 0; acc_vld = 0;
    model_upd(4'b0, 64'b0, av, ad);
    e = 0;
    cyc = 0;
    while (e < NCH && cyc < 200) begin
      out_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      acc_vld = (poke && cyc == 1) ? 4'b0010 : 4'b0;
      if (poke && cyc == 1) m_drop = 1'b1;
      total_n++;
      if (out_vld !== 1'b1 || busy !== 1'b1)
        $display("FAIL drain_vld ch%0d: out_vld=%b busy=%b want 1 1", e, out_vld, busy);
      else pass_n++;
      total_n++;
      if (out_ch !== 2'(e)) $display("FAIL drain_ch: out_ch=%0d want %0d", out_ch, e);
      else pass_n++;
      total_n++;
      if (out_wide !== 16'(m[e])) $display("FAIL drain_wide ch%0d: got %h want %h", e, out_wide, 16'(m[e]));
      else pass_n++;
      total_n++;
      if (out_narrow !== 8'(narrow(m[e], s)))
        $display("FAIL drain_narrow ch%0d s=%0d: got %h want %h", e, s, out_narrow, 8'(narrow(m[e], s)));
      else pass_n++;
      total_n++;
      if (out_last !== (e == NCH - 1)) $display("FAIL drain_last ch%0d: got %b", e, out_last);
      else pass_n++;
      if (out_rdy) begin
        if (clr) begin m[e] = 0; m_sat[e] = 1'b0; end
        e++;
      end
      tick;
      cyc++;
    end
    acc_vld = 0;
    out_rdy = 0;
    total_n++;
    if (cyc >= 200 || busy !== 1'b0 || out_vld !== 1'b0)
      $display("FAIL drain_end: busy=%b out_vld=%b cycles=%0d want idle", busy, out_vld, cyc);
    else pass_n++;
  endtask

  task automatic check_flags(input string tag);
    total_n++;
    if (sat_flag !== m_sat || drop_err !== m_drop)
      $display("FAIL %s_flags: sat=%b drop=%b want sat=%b drop=%b", tag, sat_flag, drop_err, m_sat, m_drop);
    else pass_n++;
  endtask

  task automatic test_reset;
    total_n++;
    if (out_vld !== 0 || busy !== 0 || out_ch !== 0 || out_last !== 0 || out_wide !== 0 ||
        sat_flag !== 0 || drop_err !== 0)
      $display("FAIL reset: vld=%b busy=%b ch=%0d last=%b wide=%h sat=%b drop=%b want all 0",
               out_vld, busy, out_ch, out_last, out_wide, sat_flag, drop_err);
    else pass_n++;
  endtask

  task automatic test_overflow;
    step(4'b0001, 64'h7FF0, 4'b0, 64'b0);
    step(4'b0, 64'b0, 4'b0001, 64'h0020);
    total_n++;
    if (out_wide !== 16'h7FFF || sat_flag[0] !== 1'b1)
      $display("FAIL overflow: wide=%h sat0=%b want 7fff 1", out_wide, sat_flag[0]);
    else pass_n++;
    step(4'b0, 64'b0, 4'b0001, 64'hFFFF);
    total_n++;
    if (out_wide !== 16'h7FFE || sat_flag[0] !== 1'b1)
      $display("FAIL overflow_sticky: wide=%h sat0=%b want 7ffe 1", out_wide, sat_flag[0]);
    else pass_n++;
  endtask

  task automatic test_underflow;
    step(4'b0010, 64'h8005 << 16, 4'b0, 64'b0);
    step(4'b0, 64'b0, 4'b0010, 64'hFFF0 << 16);
    total_n++;
    if (m[1] != -32768) $display("FAIL underflow_model: model=%0d want -32768", m[1]);
    else pass_n++;
    step(4'b0100, 64'h1234 << 32, 4'b0100, 64'h0001 << 32);
    check_flags("underflow");
    drain(0, 0, 0, 0, 4'b0, 64'b0);
  endtask

  task automatic test_cast;
    step(4'b1111, {16'hFFFA, 16'h0006, 16'hFF80, 16'h0123}, 4'b0, 64'b0);
    drain(0, 0, 0, 0, 4'b0, 64'b0);
    drain(2, 0, 0, 0, 4'b0, 64'b0);
    step(4'b0010, 64'hFF7F << 16, 4'b0, 64'b0);
    drain(0, 0, 2, 0, 4'b0, 64'b0);
    total_n++;
    if (narrow(291, 2) != 8'h49 || narrow(-129, 0) != -128 || narrow(-6, 2) != -1)
      $display("FAIL cast_model: narrow reference disagrees with known vectors");
    else pass_n++;
  endtask

  task automatic test_drain_clr;
    drain(1, 1, 1, 1, 4'b0, 64'b0);
    check_flags("drain_clr");
    drain(3, 0, 0, 0, 4'b0, 64'b0);
  endtask

  task automatic test_acc_clr_mid;
    step(4'b1111, {16'h0400, 16'hFC00, 16'h7000, 16'h0011}, 4'b0, 64'b0);
    drain_start = 1; out_rdy = 1;
    tick;
    drain_start = 0;
    tick;
    acc_clr = 1;
    tick;
    acc_clr = 0; out_rdy = 0;
    model_clear();
    total_n++;
    if (out_vld !== 0 || busy !== 0 || out_wide !== 0)
      $display("FAIL acc_clr_mid: vld=%b busy=%b wide=%h want 0 0 0", out_vld, busy, out_wide);
    else pass_n++;
    check_flags("acc_clr");
    drain(0, 0, 0, 0, 4'b0, 64'b0);
  endtask

  task automatic test_back_to_back;
    step(4'b0001, 64'h0100, 4'b0, 64'b0);
    drain(4, 0, 0, 0, 4'b0001, 64'h0055);
    total_n++;
    if (m[0] != 16'h0155) $display("FAIL b2b_model: model=%h want 0155", m[0]);
    else pass_n++;
  endtask

  task automatic test_async_reset;
    drain_start = 1;
    tick;
    drain_start = 0;
    tick;
    rst_n = 0;
    #1;
    model_clear();
    total_n++;
    if (out_vld !== 0 || busy !== 0 || out_ch !== 0 || out_wide !== 0 || sat_flag !== 0)
      $display("FAIL async_reset: vld=%b busy=%b ch=%0d wide=%h sat=%b want 0",
               out_vld, busy, out_ch, out_wide, sat_flag);
    else pass_n++;
    tick;
    rst_n = 1;
    tick;
  endtask

  task automatic test_random;
    logic [3:0] lv, av;
    logic [63:0] ld, ad;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 10; i++) begin
        lv = 4'($urandom) & 4'($urandom);
        av = 4'($urandom);
        ld = {$urandom, $urandom};
        ad = {$urandom, $urandom};
        step(lv, ld, av, ad);
      end
      check_flags("random");
      drain($urandom_range(0, 15), 1'($urandom), 2, 1'($urandom), 4'($urandom), {$urandom, $urandom});
      check_flags("random_post");
    end
  endtask

  initial begin
    model_clear();
    tick;
    tick;
    rst_n = 1;
    tick;
    test_reset();
    test_overflow();
    test_underflow();
    test_cast();
    test_drain_clr();
    test_acc_clr_mid();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
